// File: rtl/store_buffer.sv
// Posted-write FIFO between the execute/memory stage and the data memory.
// Drains one store per free memory cycle and forwards pending data to hitting loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [AW-1:0]                st_addr,
  input  logic [DW-1:0]                st_data,
  input  logic [31:0]                  st_pc,
  output logic                         st_ready,
  input  logic                         ld_req,
  input  logic [AW-1:0]                ld_addr,
  output logic                         ld_hit,
  output logic [DW-1:0]                ld_data,
  input  logic                         dm_busy,
  output logic                         dm_wr_en,
  output logic [AW-1:0]                dm_addr,
  output logic [DW-1:0]                dm_wdata,
  output logic [31:0]                  dm_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          enq;
  logic          drain;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign st_ready = !full;
  assign count    = count_reg;

  assign enq      = st_valid & st_ready;
  assign drain    = !empty & !dm_busy;
  assign dm_wr_en = drain;

  // Head entry is presented even while dm_busy so the write is ready the moment the port frees.
  assign dm_addr  = empty ? '0 : addr_mem[rd_ptr_reg];
  assign dm_wdata = empty ? '0 : data_mem[rd_ptr_reg];
  assign dm_pc    = empty ? '0 : pc_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    unique case ({enq, drain})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (drain) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= st_addr;
      data_mem[wr_ptr_reg] <= st_data;
      pc_mem[wr_ptr_reg]   <= st_pc;
    end
  end

  // Entries are examined by age (0 = oldest at rd_ptr); a later match overrides, so the youngest wins.
  logic [PW-1:0]    age_idx [DEPTH];
  logic [DEPTH-1:0] age_match;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi]   = rd_ptr_reg + PW'(gi);
      assign age_match[gi] = (CW'(gi) < count_reg) && (addr_mem[age_idx[gi]] == ld_addr);
    end
  endgenerate

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_match[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[age_idx[i]];
      end
    end
  end

  assign ld_hit  = ld_req & fwd_hit;
  assign ld_data = ld_hit ? fwd_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model of the FIFO,
// drain log and youngest-match forwarding, driven by directed and random stimulus.
module tb_store_buffer;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [9:0]  st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_req;
  logic [9:0]  ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        dm_busy;
  logic        dm_wr_en;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int errors = 0;
  int checks = 0;

  ent_t q[$];        // reference contents, oldest first
  ent_t exp_log[$];  // writes the model expects, in order
  ent_t obs_log[$];  // writes seen on the memory port

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(10), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .dm_busy(dm_busy), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .count(count), .empty(empty), .full(full)
  );

  // Youngest buffered store to address a, straight from the model queue.
  function automatic bit model_fwd(input logic [9:0] a, output logic [31:0] d);
    bit hit = 1'b0;
    d = '0;
    foreach (q[i]) begin
      if (q[i].a == a) begin
        hit = 1'b1;
        d   = q[i].d;
      end
    end
    return hit;
  endfunction

  // One clock: log the port, then apply the buffer rules to the model at the edge.
  task automatic cycle();
    bit   acc;
    bit   drn;
    ent_t e;
    #1;
    if (!reset && dm_wr_en) begin
      e.a = dm_addr; e.d = dm_wdata; e.pc = dm_pc;
      obs_log.push_back(e);
      $display("write addr=%03h data=%08h pc=%08h", dm_addr, dm_wdata, dm_pc);
    end
    acc = !reset && st_valid && (q.size() < 4);
    drn = !reset && (q.size() > 0) && !dm_busy;
    if (drn) exp_log.push_back(q[0]);
    e.a = st_addr; e.d = st_data; e.pc = st_pc;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (drn) q.delete(0);
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic set_store(input bit v, input logic [9:0] a, input logic [31:0] d, input logic [31:0] pc);
    st_valid = v; st_addr = a; st_data = d; st_pc = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; dm_busy = 1'b0; ld_req = 1'b0; ld_addr = '0;
    set_store(1'b0, '0, '0, '0);
    cycle(); cycle();
    reset = 1'b0; ld_req = 1'b1; ld_addr = 10'($urandom_range(0, 1023));
    #1;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (dm_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", dm_wr_en); end
    checks++; if (ld_hit !== 1'b0)   begin errors++; $display("FAIL reset_ld_hit: got %b want 0", ld_hit); end
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data: got %h want 0", ld_data); end
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    ld_req = 1'b0;
  endtask

  task automatic test_single_store();
    set_store(1'b1, 10'h010, 32'hDEADBEEF, 32'h3000);
    cycle();
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++; if (dm_wr_en !== 1'b1)        begin errors++; $display("FAIL single_wr_en: got %b want 1", dm_wr_en); end
    checks++; if (dm_addr !== 10'h010)      begin errors++; $display("FAIL single_addr: got %h want 010", dm_addr); end
    checks++; if (dm_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", dm_wdata); end
    checks++; if (dm_pc !== 32'h3000)       begin errors++; $display("FAIL single_pc: got %h want 3000", dm_pc); end
    cycle();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b want 1", empty); end
    checks++; if (dm_wr_en !== 1'b0) begin errors++; $display("FAIL single_no_rewrite: got %b want 0", dm_wr_en); end
    checks++; if (obs_log.size() != 1) begin errors++; $display("FAIL single_write_count: got %0d want 1", obs_log.size()); end
    obs_log.delete(); exp_log.delete();
  endtask

  task automatic test_full_stall();
    ent_t pushed[$];
    ent_t e;
    dm_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.a = 10'(12'h100 + i); e.d = $urandom; e.pc = 32'h4000 + 32'(4 * i);
      pushed.push_back(e);
      set_store(1'b1, e.a, e.d, e.pc);
      cycle();
    end
    #1;
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL stall_full: got %b want 1", full); end
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", st_ready); end
    checks++; if (dm_wr_en !== 1'b0) begin errors++; $display("FAIL stall_busy_inhibit: got %b want 0", dm_wr_en); end
    set_store(1'b1, 10'h3FF, 32'hBAD0BAD0, 32'hFFFF0000);
    cycle();
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_fifth_ignored: count got %0d want 4", count); end
    dm_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dm_wr_en !== 1'b1 || dm_addr !== pushed[i].a || dm_wdata !== pushed[i].d || dm_pc !== pushed[i].pc) begin
        errors++;
        $display("FAIL stall_drain_%0d: got en=%b a=%h d=%h pc=%h want en=1 a=%h d=%h pc=%h",
                 i, dm_wr_en, dm_addr, dm_wdata, dm_pc, pushed[i].a, pushed[i].d, pushed[i].pc);
      end
      cycle();
    end
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stall_empty_after: got %b want 1", empty); end
    obs_log.delete(); exp_log.delete();
  endtask

  task automatic test_forwarding();
    logic [31:0] md;
    bit mh;
    dm_busy = 1'b1;
    set_store(1'b1, 10'd5, 32'h11, 32'h5000); cycle();
    set_store(1'b1, 10'd5, 32'h22, 32'h5004); cycle();
    set_store(1'b1, 10'd9, 32'h99, 32'h5008);
    ld_req = 1'b1; ld_addr = 10'd9;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle_store: hit got %b want 0", ld_hit); end
    cycle();
    set_store(1'b0, '0, '0, '0);
    ld_addr = 10'd5;
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h want hit=1 data=22", ld_hit, ld_data); end
    ld_addr = 10'd6;
    #1;
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL fwd_miss: got hit=%b data=%h want hit=0 data=0", ld_hit, ld_data); end
    ld_req = 1'b0; ld_addr = 10'd5;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_no_req: hit got %b want 0", ld_hit); end
    ld_req = 1'b1; dm_busy = 1'b0;
    for (int i = 0; i < 6 && q.size() > 0; i++) begin
      ld_addr = (i % 2 == 0) ? 10'd5 : 10'd9;
      #1;
      mh = model_fwd(ld_addr, md);
      checks++; if (ld_hit !== mh || ld_data !== md) begin errors++; $display("FAIL fwd_while_drain_%0d: got hit=%b data=%h want hit=%b data=%h", i, ld_hit, ld_data, mh, md); end
      cycle();
    end
    ld_req = 1'b0;
    obs_log.delete(); exp_log.delete();
  endtask

  task automatic test_full_simul();
    dm_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 10'(12'h200 + i), 32'hA000_0000 + 32'(i), 32'h6000 + 32'(4 * i));
      cycle();
    end
    set_store(1'b1, 10'h2AA, 32'hCAFEF00D, 32'h6100);
    dm_busy = 1'b0;
    #1;
    checks++; if (st_ready !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL simul_blocked: got ready=%b full=%b want ready=0 full=1", st_ready, full); end
    cycle();
    #1;
    checks++; if (st_ready !== 1'b1 || count !== 3'(q.size())) begin errors++; $display("FAIL simul_after_drain: got ready=%b count=%0d want ready=1 count=%0d", st_ready, count, q.size()); end
    cycle();
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL simul_count: got %0d want %0d", count, q.size()); end
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    checks++; if (obs_log.size() != 5 || obs_log[4] !== {10'h2AA, 32'hCAFEF00D, 32'h6100}) begin
      errors++; $display("FAIL simul_held_store: got %0d writes, last=%h want 5 writes ending with the held store", obs_log.size(), obs_log.size() ? obs_log[obs_log.size()-1] : '0);
    end
    checks++; if (obs_log !== exp_log) begin errors++; $display("FAIL simul_order: got %0d writes want %0d in model order", obs_log.size(), exp_log.size()); end
    obs_log.delete(); exp_log.delete();
  endtask

  task automatic test_wrap_random();
    ent_t plan[$];
    ent_t e;
    logic [31:0] md;
    bit mh;
    int idx = 0;
    for (int i = 0; i < 7; i++) begin
      e.a = 10'($urandom_range(0, 7)); e.d = $urandom; e.pc = 32'h7000 + 32'(4 * i);
      plan.push_back(e);
    end
    for (int cyc = 0; cyc < 200 && (idx < 7 || q.size() > 0); cyc++) begin
      if (idx < 7 && ($urandom % 4) != 0) set_store(1'b1, plan[idx].a, plan[idx].d, plan[idx].pc);
      else set_store(1'b0, '0, '0, '0);
      dm_busy = (idx < 7) && (($urandom % 3) == 0);
      ld_req = 1'b1; ld_addr = 10'($urandom_range(0, 7));
      #1;
      mh = model_fwd(ld_addr, md);
      checks++; if (ld_hit !== mh || ld_data !== md) begin errors++; $display("FAIL wrap_fwd_cyc%0d: got hit=%b data=%h want hit=%b data=%h", cyc, ld_hit, ld_data, mh, md); end
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL wrap_count_cyc%0d: got %0d want %0d", cyc, count, q.size()); end
      if (st_valid && q.size() < 4) idx++;
      cycle();
    end
    set_store(1'b0, '0, '0, '0); ld_req = 1'b0; dm_busy = 1'b0;
    checks++; if (idx != 7 || q.size() != 0) begin errors++; $display("FAIL wrap_timeout: pushed %0d pending %0d want 7 and 0", idx, q.size()); end
    checks++; if (obs_log.size() != 7) begin errors++; $display("FAIL wrap_write_count: got %0d want 7", obs_log.size()); end
    for (int i = 0; i < 7 && i < obs_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== plan[i]) begin errors++; $display("FAIL wrap_order_%0d: got %h want %h", i, obs_log[i], plan[i]); end
    end
    obs_log.delete(); exp_log.delete();
  endtask

  task automatic test_reset_midway();
    dm_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 10'(12'h020 + i), 32'hB000_0000 + 32'(i), 32'h8000 + 32'(4 * i));
      cycle();
    end
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL midreset_pending: got %0d want 3", count); end
    reset = 1'b1; dm_busy = 1'b0;
    cycle();
    reset = 1'b0; ld_req = 1'b1; ld_addr = 10'h021;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dm_wr_en !== 1'b0 || count !== 3'd0 || st_ready !== 1'b1 || ld_hit !== 1'b0) begin
        errors++;
        $display("FAIL midreset_cyc%0d: got wr_en=%b count=%0d ready=%b hit=%b want 0 0 1 0", i, dm_wr_en, count, st_ready, ld_hit);
      end
      cycle();
    end
    ld_req = 1'b0;
    checks++; if (obs_log.size() != 0) begin errors++; $display("FAIL midreset_stale_writes: got %0d want 0", obs_log.size()); end
    obs_log.delete(); exp_log.delete();
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_req = 1'b0; ld_addr = '0; dm_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_store();
    test_full_stall();
    test_forwarding();
    test_full_simul();
    test_wrap_random();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
